// File: rtl/i2c_target_regs.sv
// I2C target with a byte-wide register-file port: START/STOP, 7-bit address, pointer, write/read bursts.
// Optional build macro I2C_TARGET_GLITCH_FILTER_EN adds a 3-sample majority filter on SCL/SDA.
module i2c_target_regs #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter logic [7:0] PTR_RESET  = 8'h00
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       SCL,
  input  logic       SDA_IN,
  output logic       SDA_OE,
  output logic [7:0] REG_ADDR,
  output logic [7:0] REG_WDATA,
  output logic       REG_WE,
  output logic       REG_RE,
  input  logic [7:0] REG_RDATA,
  output logic       BUSY
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    ADDR     = 4'd1,
    ADDR_ACK = 4'd2,
    PTR      = 4'd3,
    PTR_ACK  = 4'd4,
    WR       = 4'd5,
    WR_ACK   = 4'd6,
    RD       = 4'd7,
    RD_ACK   = 4'd8,
    SKIP     = 4'd9
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [6:0] sh_q, sh_d;
  logic       rw_q, rw_d;
  logic       phase_q, phase_d;
  logic       ld_q, ld_d;
  logic       oe_q, oe_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       we_q, we_d;
  logic       re_q, re_d;
  logic       busy_q, busy_d;

  // stage p0/p1: two-flop synchronisers, preset to the idle (released) bus level
  logic scl_p0, scl_p1, sda_p0, sda_p1;
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      scl_p0 <= 1'b1;
      scl_p1 <= 1'b1;
      sda_p0 <= 1'b1;
      sda_p1 <= 1'b1;
    end else begin
      scl_p0 <= SCL;
      scl_p1 <= scl_p0;
      sda_p0 <= SDA_IN;
      sda_p1 <= sda_p0;
    end
  end

  logic scl_l, sda_l;
`ifdef I2C_TARGET_GLITCH_FILTER_EN
  // stage p2: majority of the last three synchronised samples
  logic [1:0] scl_p2, sda_p2;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      scl_p2 <= 2'b11;
      sda_p2 <= 2'b11;
    end else begin
      scl_p2 <= {scl_p2[0], scl_p1};
      sda_p2 <= {sda_p2[0], sda_p1};
    end
  end

  assign scl_l = maj3(scl_p1, scl_p2[0], scl_p2[1]);
  assign sda_l = maj3(sda_p1, sda_p2[0], sda_p2[1]);
`else
  assign scl_l = scl_p1;
  assign sda_l = sda_p1;
`endif

  logic scl_q, sda_q;
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_l;
      sda_q <= sda_l;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] byte_in;
  assign scl_rise  = scl_l & ~scl_q;
  assign scl_fall  = ~scl_l & scl_q;
  assign start_det = scl_l & scl_q & sda_q & ~sda_l;
  assign stop_det  = scl_l & scl_q & ~sda_q & sda_l;
  assign byte_in   = {sh_q, sda_l};

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      phase_q <= 1'b0;
      ld_q    <= 1'b0;
      oe_q    <= 1'b0;
      addr_q  <= PTR_RESET;
      wdata_q <= 8'h00;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      ld_q    <= ld_d;
      oe_q    <= oe_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      re_q    <= re_d;
      busy_q  <= busy_d;
    end
  end

  always_ff @(posedge CLK) begin
    sh_q <= sh_d;
    rw_q <= rw_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    rw_d    = rw_q;
    phase_d = phase_q;
    ld_d    = 1'b0;
    oe_d    = oe_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    re_d    = 1'b0;
    busy_d  = busy_q;
    if (start_det) begin
      state_d = ADDR;
      cnt_d   = 3'd0;
      phase_d = 1'b0;
      oe_d    = 1'b0;
    end else if (stop_det) begin
      state_d = IDLE;
      phase_d = 1'b0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (ld_q) begin
      // read data arrives one CLK after REG_RE; MSB goes straight onto the bus
      sh_d  = REG_RDATA[6:0];
      oe_d  = ~REG_RDATA[7];
      cnt_d = 3'd0;
    end else begin
      case (state_q)
        ADDR: if (scl_rise) begin
          sh_d  = byte_in[6:0];
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            if (sh_q == SLAVE_ADDR) begin
              state_d = ADDR_ACK;
              rw_d    = sda_l;
              phase_d = 1'b0;
              busy_d  = 1'b1;
            end else begin
              state_d = SKIP;
              busy_d  = 1'b0;
            end
          end
        end
        ADDR_ACK, PTR_ACK, WR_ACK: begin
          // phase marks that the master has clocked our ACK bit
          if (scl_fall) begin
            if (!phase_q) begin
              oe_d = 1'b1;
            end else begin
              oe_d    = 1'b0;
              phase_d = 1'b0;
              cnt_d   = 3'd0;
              if (state_q == ADDR_ACK) begin
                if (rw_q) begin
                  state_d = RD;
                  re_d    = 1'b1;
                  ld_d    = 1'b1;
                end else begin
                  state_d = PTR;
                end
              end else if (state_q == PTR_ACK) begin
                state_d = WR;
              end else begin
                state_d = WR;
                addr_d  = addr_q + 8'd1;
              end
            end
          end else if (scl_rise && oe_q) begin
            phase_d = 1'b1;
          end
        end
        PTR: if (scl_rise) begin
          sh_d  = byte_in[6:0];
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            addr_d  = byte_in;
            state_d = PTR_ACK;
            phase_d = 1'b0;
          end
        end
        WR: if (scl_rise) begin
          sh_d  = byte_in[6:0];
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            wdata_d = byte_in;
            we_d    = 1'b1;
            state_d = WR_ACK;
            phase_d = 1'b0;
          end
        end
        RD: begin
          if (scl_fall) begin
            oe_d = ~sh_q[6];
            sh_d = {sh_q[5:0], 1'b0};
          end else if (scl_rise) begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              state_d = RD_ACK;
              phase_d = 1'b0;
            end
          end
        end
        RD_ACK: begin
          // the pointer advances past every byte sent, whether ACKed or NACKed
          if (scl_fall) begin
            if (!phase_q) begin
              oe_d = 1'b0;
            end else begin
              phase_d = 1'b0;
              state_d = RD;
              re_d    = 1'b1;
              ld_d    = 1'b1;
            end
          end else if (scl_rise && !phase_q) begin
            addr_d = addr_q + 8'd1;
            if (sda_l) begin
              state_d = SKIP;
              busy_d  = 1'b0;
            end else begin
              phase_d = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign SDA_OE    = oe_q;
  assign REG_ADDR  = addr_q;
  assign REG_WDATA = wdata_q;
  assign REG_WE    = we_q;
  assign REG_RE    = re_q;
  assign BUSY      = busy_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Self-checking bench for i2c_target_regs: bus-master tasks, write-vector table and read/reset/glitch sequences.
`timescale 1ns/1ps
module tb_i2c_target_regs;

  localparam int Q = 8;
  localparam logic [7:0] PTR_RST = 8'h00;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       SCL;
  logic       sda_m;
  logic       SDA_IN;
  logic       SDA_OE;
  logic [7:0] REG_ADDR;
  logic [7:0] REG_WDATA;
  logic       REG_WE;
  logic       REG_RE;
  logic [7:0] REG_RDATA;
  logic       BUSY;

  function automatic logic [7:0] mem(input logic [7:0] a);
    return a ^ 8'hFF;
  endfunction

  assign SDA_IN    = sda_m & ~SDA_OE;
  assign REG_RDATA = mem(REG_ADDR);

  always #5 CLK = ~CLK;

  i2c_target_regs #(.SLAVE_ADDR(7'h50), .PTR_RESET(PTR_RST)) dut (
    .CLK(CLK), .RST_N(RST_N), .SCL(SCL), .SDA_IN(SDA_IN), .SDA_OE(SDA_OE),
    .REG_ADDR(REG_ADDR), .REG_WDATA(REG_WDATA), .REG_WE(REG_WE), .REG_RE(REG_RE),
    .REG_RDATA(REG_RDATA), .BUSY(BUSY)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // observed DUT events
  logic [15:0] obs_q[$];
  int re_cnt = 0;
  int viol = 0;
  int oe_cnt = 0;
  logic we_prev = 1'b0;
  logic re_prev = 1'b0;

  always @(negedge CLK) begin
    if (REG_WE) obs_q.push_back({REG_ADDR, REG_WDATA});
    if (REG_RE) re_cnt <= re_cnt + 1;
    if (SDA_OE) oe_cnt <= oe_cnt + 1;
    if ((REG_WE && REG_RE) || (REG_WE && we_prev) || (REG_RE && re_prev)) viol <= viol + 1;
    we_prev <= REG_WE;
    re_prev <= REG_RE;
  end

  logic [15:0] exp_q[$];
  logic [7:0]  rd_q[$];

  task automatic qwait();
    repeat (Q) @(negedge CLK);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; qwait();
    SCL = 1'b1;   qwait();
    sda_m = 1'b0; qwait();
    SCL = 1'b0;   qwait();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; qwait();
    SCL = 1'b1;   qwait();
    sda_m = 1'b1; qwait();
    qwait();
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; qwait();
    SCL = 1'b1; qwait(); qwait();
    SCL = 1'b0; qwait();
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1; qwait();
    SCL = 1'b1; qwait();
    b = SDA_IN; qwait();
    SCL = 1'b0; qwait();
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(nack);
    sda_m = 1'b1;
  endtask

  task automatic drain_we();
    logic [15:0] e, o;
    while (exp_q.size() > 0) begin
      if (obs_q.size() == 0) begin
        check("we_count", obs_q.size(), exp_q.size());
        exp_q.delete();
      end else begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        check("we_addr", o[15:8], e[15:8]);
        check("we_data", o[7:0], e[7:0]);
      end
    end
    check("we_extra", obs_q.size(), 0);
    obs_q.delete();
  endtask

  task automatic pulse_reset();
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  typedef struct {
    logic [6:0] dev;
    logic [7:0] ptr;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       ack;
    logic [7:0] addr_after;
  } wvec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    wvec_t vecs[4];
    logic ack;
    logic [7:0] b, e, a;
    logic b7, b6, b5;
    int re0, oe0, seen;
    logic [3:0] st;

    vecs[0] = '{7'h50, 8'hFF, 8'h01, 8'h02, 1'b1, 8'h01};
    vecs[1] = '{7'h23, 8'h77, 8'h11, 8'h22, 1'b0, 8'h01};
    vecs[2] = '{7'h50, 8'h80, 8'h00, 8'hFF, 1'b1, 8'h82};
    vecs[3] = '{7'h50, 8'h10, 8'hA5, 8'h3C, 1'b1, 8'h12};

    RST_N = 1'b0;
    SCL   = 1'b1;
    sda_m = 1'b1;
    repeat (5) @(negedge CLK);
    check("rst_sda_oe", SDA_OE, 1'b0);
    check("rst_we", REG_WE, 1'b0);
    check("rst_re", REG_RE, 1'b0);
    check("rst_busy", BUSY, 1'b0);
    check("rst_addr", REG_ADDR, PTR_RST);
    check("rst_wdata", REG_WDATA, 8'h00);
    RST_N = 1'b1;
    qwait();

    // write transactions: wrap, address mismatch, plain bursts
    for (int v = 0; v < 4; v++) begin
      oe0 = oe_cnt;
      bus_start();
      send_byte({vecs[v].dev, 1'b0}, ack);
      check("addr_ack", ack, vecs[v].ack);
      check("busy_after_addr", BUSY, vecs[v].ack);
      send_byte(vecs[v].ptr, ack);
      check("ptr_ack", ack, vecs[v].ack);
      if (vecs[v].ack) exp_q.push_back({vecs[v].ptr, vecs[v].d0});
      send_byte(vecs[v].d0, ack);
      check("d0_ack", ack, vecs[v].ack);
      a = vecs[v].ptr + 8'd1;
      if (vecs[v].ack) exp_q.push_back({a, vecs[v].d1});
      send_byte(vecs[v].d1, ack);
      check("d1_ack", ack, vecs[v].ack);
      bus_stop();
      check("busy_after_stop", BUSY, 1'b0);
      check("addr_after_stop", REG_ADDR, vecs[v].addr_after);
      drain_we();
      if (!vecs[v].ack) check("mismatch_sda_quiet", oe_cnt - oe0, 0);
    end

    // current-address read from 0x12: ACK, ACK, NACK
    re0 = re_cnt;
    bus_start();
    send_byte(8'hA1, ack);
    check("rd_addr_ack", ack, 1'b1);
    for (int i = 0; i < 3; i++) begin
      a = 8'h12 + 8'(i);
      rd_q.push_back(mem(a));
      read_byte(b, (i == 2));
      e = rd_q.pop_front();
      check("rd_byte", b, e);
    end
    check("busy_after_nack", BUSY, 1'b0);
    bus_stop();
    check("rd_re_count", re_cnt - re0, 3);
    check("rd_addr_after", REG_ADDR, 8'h15);
    drain_we();

    // pointer write, repeated START, read, then reset mid-byte
    bus_start();
    send_byte(8'hA0, ack);
    check("rs_addr_ack", ack, 1'b1);
    send_byte(8'h20, ack);
    check("rs_ptr_ack", ack, 1'b1);
    bus_start();
    send_byte(8'hA1, ack);
    check("rs_rd_ack", ack, 1'b1);
    check("rs_busy", BUSY, 1'b1);
    rd_q.push_back(mem(8'h20));
    read_byte(b, 1'b0);
    e = rd_q.pop_front();
    check("rs_rd_byte", b, e);
    recv_bit(b7);
    recv_bit(b6);
    recv_bit(b5);
    check("rs_partial_bits", {b7, b6, b5}, 3'b110);
    sda_m = 1'b1; qwait();
    SCL = 1'b1; qwait();
    pulse_reset();
    check("mid_rst_sda_oe", SDA_OE, 1'b0);
    check("mid_rst_we", REG_WE, 1'b0);
    check("mid_rst_re", REG_RE, 1'b0);
    check("mid_rst_busy", BUSY, 1'b0);
    check("mid_rst_addr", REG_ADDR, PTR_RST);
    check("mid_rst_wdata", REG_WDATA, 8'h00);
    qwait();
    SCL = 1'b0; qwait();
    bus_stop();
    drain_we();

    // reset while the target is pulling SDA low for the address ACK
    bus_start();
    for (int i = 7; i >= 0; i--) send_bit(8'hA0 >> i);
    sda_m = 1'b1; qwait();
    check("ack_drive_oe", SDA_OE, 1'b1);
    check("ack_drive_busy", BUSY, 1'b1);
    pulse_reset();
    check("ack_rst_sda_oe", SDA_OE, 1'b0);
    check("ack_rst_busy", BUSY, 1'b0);
    bus_stop();
    check("ack_rst_idle_oe", SDA_OE, 1'b0);

    // 1-CLK SDA low glitch while SCL is high on an idle bus
    SCL = 1'b1; sda_m = 1'b1;
    qwait();
    seen = 0;
    oe0 = oe_cnt;
    sda_m = 1'b0;
    @(negedge CLK);
    sda_m = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      st = dut.state_q;
      if (st == 4'd1) seen = 1;
    end
`ifdef I2C_TARGET_GLITCH_FILTER_EN
    check("glitch_start_seen", seen, 0);
`else
    check("glitch_start_seen", seen, 1);
`endif
    check("glitch_busy", BUSY, 1'b0);
    check("glitch_sda_quiet", oe_cnt - oe0, 0);
    qwait();

    check("pulse_violations", viol, 0);
    drain_we();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
